// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: state encoding and default sizing.
package reaction_timer_pkg;

  localparam int MAX_MS_DEF = 9999;
  localparam int CNT_W_DEF  = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_TIMING = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

endpackage

// File: rtl/reaction_timer_key_sync_edge.sv
// Multi-flop synchroniser followed by a registered rising-edge pulse.
// A rising input yields a one-clk pulse STAGES+1 clocks later; a held level yields one pulse.
module reaction_timer_key_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], d_i};
      prev_q  <= sync_q[STAGES-1];
      pulse_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: measures ms from lights-out to key press, flags false starts and
// timeouts, and keeps the best valid time. Handshake: all pulses are one clk wide, no ready.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int MAX_MS      = MAX_MS_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic             arm,
  input  logic             lights_out,
  input  logic             key_in,
  output logic [CNT_W-1:0] react_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic             result_valid,
  output logic             false_start,
  output logic             timeout,
  output logic             busy,
  output state_e           state_dbg
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_MS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] react_q, react_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             to_q, to_d;
  logic             busy_q, busy_d;
  logic             lo_prev_q;
  logic             press;
  logic             go;

  reaction_timer_key_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_key (
    .clk     (clk),
    .rst     (rst),
    .d_i     (key_in),
    .pulse_o (press)
  );

  // lights_out comes from the same clock domain, so a single delay flop suffices.
  assign go = lights_out & ~lo_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    react_d = react_q;
    best_d  = best_q;
    valid_d = 1'b0;
    fs_d    = fs_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (press) begin
          state_d = ST_FAULT;
          fs_d    = 1'b1;
        end else if (go) begin
          state_d = ST_TIMING;
          cnt_d   = '0;
        end
      end
      ST_TIMING: begin
        // A press in the same clk as a tick captures the pre-increment count.
        if (press) begin
          state_d = ST_DONE;
          react_d = cnt_q;
          valid_d = 1'b1;
          if (cnt_q < best_q) begin
            best_d = cnt_q;
          end
        end else if (tick_1ms) begin
          if (cnt_q >= MAX_V - CNT_W'(1)) begin
            cnt_d   = MAX_V;
            state_d = ST_DONE;
            to_d    = 1'b1;
            react_d = MAX_V;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE, ST_FAULT: begin
        if (arm) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
          fs_d    = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARMED) || (state_d == ST_TIMING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      react_q   <= '0;
      best_q    <= MAX_V;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
      lo_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      react_q   <= react_d;
      best_q    <= best_d;
      valid_q   <= valid_d;
      fs_q      <= fs_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
      lo_prev_q <= lights_out;
    end
  end

  assign react_ms     = react_q;
  assign best_ms      = best_q;
  assign result_valid = valid_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: directed rounds, a ms-level reference model checked every
// cycle, and hand-computed expectations after each scenario.
module tb_reaction_timer;
  import reaction_timer_pkg::*;

  localparam int S    = 2;
  localparam int MAXV = 9999;

  localparam int P_IDLE   = 0;
  localparam int P_ARMED  = 1;
  localparam int P_TIMING = 2;
  localparam int P_DONE   = 3;
  localparam int P_FAULT  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        tick_1ms, arm, lights_out, key_in;
  logic [13:0] react_ms, best_ms;
  logic        result_valid, false_start, timeout, busy;
  state_e      state_dbg;

  reaction_timer dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1ms     (tick_1ms),
    .arm          (arm),
    .lights_out   (lights_out),
    .key_in       (key_in),
    .react_ms     (react_ms),
    .best_ms      (best_ms),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in terms of rounds and elapsed ms; a key press is seen S+1 clks after key_in rises.
  int m_phase, m_ms, m_react, m_best;
  bit m_valid, m_fs, m_to;
  bit kh[$];
  bit lo_prev;

  task automatic m_reset();
    m_phase = P_IDLE;
    m_ms    = 0;
    m_react = 0;
    m_best  = MAXV;
    m_valid = 0;
    m_fs    = 0;
    m_to    = 0;
    kh.delete();
    for (int i = 0; i < S + 2; i++) kh.push_back(1'b0);
    lo_prev = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    bit press, go;
    if (rst) begin
      m_reset();
    end else begin
      press   = kh[S] && !kh[S+1];
      go      = lights_out && !lo_prev;
      lo_prev = lights_out;
      kh.push_front(key_in);
      void'(kh.pop_back());
      m_valid = 0;
      case (m_phase)
        P_IDLE: if (arm) m_phase = P_ARMED;
        P_ARMED: begin
          if (press) begin
            m_phase = P_FAULT;
            m_fs    = 1;
          end else if (go) begin
            m_phase = P_TIMING;
            m_ms    = 0;
          end
        end
        P_TIMING: begin
          if (press) begin
            m_phase = P_DONE;
            m_react = m_ms;
            m_valid = 1;
            m_best  = (m_ms < m_best) ? m_ms : m_best;
          end else if (tick_1ms) begin
            m_ms++;
            if (m_ms >= MAXV) begin
              m_phase = P_DONE;
              m_to    = 1;
              m_react = MAXV;
              m_valid = 1;
            end
          end
        end
        default: begin
          if (arm) begin
            m_phase = P_ARMED;
            m_fs    = 0;
            m_to    = 0;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    cmp("react_ms", 32'(react_ms), 32'(m_react));
    cmp("best_ms", 32'(best_ms), 32'(m_best));
    cmp("result_valid", 32'(result_valid), 32'(m_valid));
    cmp("false_start", 32'(false_start), 32'(m_fs));
    cmp("timeout", 32'(timeout), 32'(m_to));
    cmp("busy", 32'(busy), 32'((m_phase == P_ARMED) || (m_phase == P_TIMING)));
    if (result_valid === 1'b1) n_valid++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic start_round();
    arm = 1'b1;
    step();
    arm = 1'b0;
    step(2);
    lights_out = 1'b1;
    step();
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      tick_1ms = 1'b1;
      step();
      tick_1ms = 1'b0;
      step(gap);
    end
  endtask

  task automatic press_key();
    key_in = 1'b1;
    step(6);
    key_in     = 1'b0;
    lights_out = 1'b0;
    step(2);
  endtask

  // ---------------- directed scenarios ----------------
  int v0;
  int rounds[3] = '{300, 180, 250};
  int bests[3]  = '{300, 180, 180};

  initial begin
    tick_1ms = 0; arm = 0; lights_out = 0; key_in = 0;
    #2 rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();

    cmp("rst_react", 32'(react_ms), 0);
    cmp("rst_best", 32'(best_ms), 9999);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // timeout
    v0 = n_valid;
    start_round();
    cmp("to_busy", 32'(busy), 1);
    ticks(MAXV, 0);
    step(2);
    cmp("to_timeout", 32'(timeout), 1);
    cmp("to_react", 32'(react_ms), 9999);
    cmp("to_best", 32'(best_ms), 9999);
    cmp("to_busy_done", 32'(busy), 0);
    ticks(5, 0);
    cmp("to_valid_cnt", n_valid - v0, 1);
    lights_out = 0;
    step();

    // valid reaction of 237 ms
    v0 = n_valid;
    start_round();
    cmp("v_timeout_clr", 32'(timeout), 0);
    ticks(237, 1);
    press_key();
    cmp("v_react", 32'(react_ms), 237);
    cmp("v_best", 32'(best_ms), 237);
    cmp("v_busy", 32'(busy), 0);
    cmp("v_fs", 32'(false_start), 0);
    cmp("v_valid_cnt", n_valid - v0, 1);

    // false start
    v0 = n_valid;
    arm = 1; step(); arm = 0;
    step();
    key_in = 1;
    step(5);
    cmp("fs_flag", 32'(false_start), 1);
    cmp("fs_react", 32'(react_ms), 237);
    cmp("fs_best", 32'(best_ms), 237);
    cmp("fs_valid_cnt", n_valid - v0, 0);
    key_in = 0;
    step(2);
    arm = 1; step(); arm = 0;
    cmp("fs_clear", 32'(false_start), 0);
    cmp("fs_rearm_busy", 32'(busy), 1);
    lights_out = 1; step();
    ticks(20, 0);
    press_key();
    cmp("fs_next_react", 32'(react_ms), 20);

    // best tracking from a fresh reset
    do_reset();
    for (int r = 0; r < 3; r++) begin
      start_round();
      ticks(rounds[r], 0);
      press_key();
      cmp("bt_best", 32'(best_ms), 32'(bests[r]));
    end
    cmp("bt_react", 32'(react_ms), 250);

    // press coinciding with a tick at count 41
    start_round();
    ticks(41, 0);
    key_in = 1;
    step(3);
    tick_1ms = 1;
    step();
    tick_1ms = 0;
    step(2);
    key_in = 0; lights_out = 0;
    step(2);
    cmp("co_react", 32'(react_ms), 41);
    cmp("co_best", 32'(best_ms), 41);

    // press and go in the same clk
    v0 = n_valid;
    arm = 1; step(); arm = 0;
    key_in = 1;
    step(3);
    lights_out = 1;
    step(2);
    cmp("pg_fs", 32'(false_start), 1);
    cmp("pg_busy", 32'(busy), 0);
    lights_out = 0;
    step();

    // key held across the next round: no spurious press
    start_round();
    ticks(30, 0);
    step(5);
    cmp("hold_busy", 32'(busy), 1);
    cmp("hold_valid_cnt", n_valid - v0, 0);
    key_in = 0;
    step(3);
    press_key();
    cmp("hold_react", 32'(react_ms), 30);
    cmp("hold_best", 32'(best_ms), 30);

    // asynchronous reset in the middle of timing
    v0 = n_valid;
    start_round();
    ticks(500, 0);
    #2 rst = 1'b1;
    #1;
    cmp("ar_react", 32'(react_ms), 0);
    cmp("ar_best", 32'(best_ms), 9999);
    cmp("ar_valid", 32'(result_valid), 0);
    cmp("ar_busy", 32'(busy), 0);
    cmp("ar_state", 32'(state_dbg), 32'(ST_IDLE));
    step();
    rst = 1'b0;
    lights_out = 0;
    step(3);
    cmp("ar_state_after", 32'(state_dbg), 32'(ST_IDLE));
    cmp("ar_valid_cnt", n_valid - v0, 0);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Downstream stage of the start-light sequencer and random-delay path.
- Measures the time in milliseconds from lights-out to the player's key press.
- Flags false starts and timeouts, and keeps a running best time.
- Its binary outputs feed the BCD conversion and 7-segment display chain.

Parameters:
- MAX_MS, 9999: saturation and timeout limit in ms. Chosen to fit four display digits.
- CNT_W, 14: width of the ms counter and result outputs. Must satisfy 2^CNT_W > MAX_MS.
- SYNC_STAGES, 2: flip-flop depth of the key synchroniser (minimum 2).

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- tick_1ms  input  1  one-clk-wide enable pulse, once per ms.
- arm  input  1  one-clk pulse from the light FSM; the light sequence has started.
- lights_out  input  1  level; high once the random delay has expired and the lights are off.
- key_in  input  1  raw active-high player button (top level inverts KEY).
- react_ms  output  CNT_W  last captured reaction time in ms.
- best_ms  output  CNT_W  smallest valid reaction time since reset.
- result_valid  output  1  one-clk pulse when react_ms is updated.
- false_start  output  1  level; the key was pressed before lights-out.
- timeout  output  1  level; no press arrived before MAX_MS.
- busy  output  1  high in ARMED or TIMING.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - react_ms = 0, best_ms = MAX_MS.
  - result_valid = 0, false_start = 0, timeout = 0, busy = 0.
  - Internal counter = 0; synchroniser flops = 0.
- Key path:
  - key_in passes through SYNC_STAGES flops, then a rising-edge detector, producing press (one clk wide).
  - Latency from key_in rising to press is SYNC_STAGES+1 clks.
  - A held key gives exactly one press.
- lights_out rising edge is detected internally, producing go (one clk wide).
- States: IDLE, ARMED, TIMING, DONE, FAULT.
- IDLE:
  - arm -> ARMED; counter cleared.
  - press and go are ignored.
- ARMED:
  - press -> FAULT, false_start = 1 from the next clk.
  - go -> TIMING, counter = 0.
  - press and go in the same clk -> FAULT (a false start wins).
- TIMING: counter increments on each tick_1ms. Three exits:
  - press -> DONE. react_ms <= counter, result_valid = 1 for one clk. If counter < best_ms, best_ms <= counter.
  - press and tick_1ms in the same clk: the pre-increment counter value is captured.
  - counter reaches MAX_MS -> DONE. timeout = 1, react_ms <= MAX_MS, result_valid pulses, best_ms unchanged. The counter never exceeds MAX_MS.
  - arm is ignored in TIMING.
- DONE / FAULT:
  - Outputs are held.
  - arm -> ARMED; false_start and timeout clear in the same transition clk. react_ms and best_ms are retained.
- Counter only advances in TIMING.
- A reaction of 0 ms (press in the first clk after go, before any tick) is valid and captured as 0.
- best_ms only decreases; only rst restores it to MAX_MS.
- busy is a registered decode of state (ARMED or TIMING).
- Reset asserted mid-TIMING: everything returns to reset values immediately, with no result_valid pulse.

Decomposition:
- Shared package holds the state encoding (localparam/typedef for IDLE..FAULT), the default MAX_MS, and CNT_W.
- One natural sub-module: key_sync_edge, the parameterised synchroniser plus rising-edge pulse generator. It can be reused for other KEY inputs.
- FSM, counter and best-time register stay in reaction_timer.

Test Plan:
1. Valid reaction:
   - Stimulus: rst, arm, go, 237 tick_1ms pulses, then key_in high.
   - Response: react_ms = 237, one result_valid pulse, best_ms = 237, busy falls, false_start = 0.
2. False start:
   - Stimulus: arm, then key_in high before lights_out.
   - Response: false_start = 1, no result_valid, react_ms and best_ms unchanged.
   - Then arm again: false_start clears and busy = 1.
3. Timeout:
   - Stimulus: arm, go, MAX_MS ticks with no key.
   - Response: timeout = 1, react_ms = 9999, result_valid pulses once, best_ms stays 9999.
4. Best tracking:
   - Stimulus: three rounds with reactions 300, 180, 250.
   - Response: best_ms sequence 300, 180, 180; react_ms = 250 after the last round.
5. Simultaneous and edge cases:
   - press coinciding with tick at count 41 captures 41.
   - press and go in the same clk -> FAULT.
   - A held key across rounds produces no spurious press.
6. Reset mid-operation:
   - Stimulus: assert rst asynchronously (off clock edge) during TIMING at count 500.
   - Response: all outputs return to reset values immediately, no result_valid, state IDLE.
